// File: rtl/trivium_pkg.sv
// Shared constants, state type and FSM encoding for the word-parallel Trivium core.
// Tap numbers are 1-indexed as in the cipher description; use sbit() to read them.
package trivium_pkg;

    localparam int STATE_LEN = 288;

    // Register boundaries: A = s1..s93, B = s94..s177, C = s178..s288
    localparam int A_END = 93;
    localparam int B_END = 177;
    localparam int C_END = 288;

    localparam int T_A_OUT0 = 66;
    localparam int T_A_OUT1 = 93;
    localparam int T_A_AND0 = 91;
    localparam int T_A_AND1 = 92;
    localparam int T_A_FB   = 171;
    localparam int T_B_OUT0 = 162;
    localparam int T_B_OUT1 = 177;
    localparam int T_B_AND0 = 175;
    localparam int T_B_AND1 = 176;
    localparam int T_B_FB   = 264;
    localparam int T_C_OUT0 = 243;
    localparam int T_C_OUT1 = 288;
    localparam int T_C_AND0 = 286;
    localparam int T_C_AND1 = 287;
    localparam int T_C_FB   = 69;

    localparam int INIT_ROUNDS_DEFAULT = 1152;

    typedef logic [STATE_LEN-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } fsm_t;

    function automatic logic sbit(input state_t s, input int n);
        return s[n-1];
    endfunction

    function automatic state_t load_state(input logic [79:0] key, input logic [79:0] iv);
        state_t s;
        s = '0;
        s[79:0]    = key;
        s[172:93]  = iv;
        s[287:285] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: 288-bit state in, next state and keystream bit out.
module trivium_round
    import trivium_pkg::*;
(
    input  state_t s_in,
    output state_t s_out,
    output logic   z
);

    logic t1;
    logic t2;
    logic t3;
    logic t1_fb;
    logic t2_fb;
    logic t3_fb;

    assign t1 = sbit(s_in, T_A_OUT0) ^ sbit(s_in, T_A_OUT1);
    assign t2 = sbit(s_in, T_B_OUT0) ^ sbit(s_in, T_B_OUT1);
    assign t3 = sbit(s_in, T_C_OUT0) ^ sbit(s_in, T_C_OUT1);
    assign z  = t1 ^ t2 ^ t3;

    assign t1_fb = t1 ^ (sbit(s_in, T_A_AND0) & sbit(s_in, T_A_AND1)) ^ sbit(s_in, T_A_FB);
    assign t2_fb = t2 ^ (sbit(s_in, T_B_AND0) & sbit(s_in, T_B_AND1)) ^ sbit(s_in, T_B_FB);
    assign t3_fb = t3 ^ (sbit(s_in, T_C_AND0) & sbit(s_in, T_C_AND1)) ^ sbit(s_in, T_C_FB);

    // Each register shifts towards its high end; feedback enters at its first bit.
    assign s_out[0]               = t3_fb;
    assign s_out[A_END-1:1]       = s_in[A_END-2:0];
    assign s_out[A_END]           = t1_fb;
    assign s_out[B_END-1:A_END+1] = s_in[B_END-2:A_END];
    assign s_out[B_END]           = t2_fb;
    assign s_out[C_END-1:B_END+1] = s_in[C_END-2:B_END];

endmodule

// File: rtl/trivium_keystream_par.sv
// W-bit-per-clock Trivium keystream generator with internal warm-up and valid/ready output.
// Optional accepted-word counter port ks_count_o when TRIVIUM_WORD_CNT_EN is defined.
module trivium_keystream_par
    import trivium_pkg::*;
#(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = INIT_ROUNDS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [79:0]  key_i,
    input  logic [79:0]  iv_i,
    input  logic         load_i,
    output logic         busy_o,
    output logic [W-1:0] ks_data_o,
    output logic         ks_valid_o,
    input  logic         ks_ready_i
`ifdef TRIVIUM_WORD_CNT_EN
    ,
    output logic [31:0]  ks_count_o
`endif
);

    localparam int INIT_STEPS = INIT_ROUNDS / W;
    localparam int CNT_W      = (INIT_STEPS > 1) ? $clog2(INIT_STEPS) : 1;

    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
        $error("trivium_keystream_par: W must be one of 1,2,4,8,16,32,64");
    end
    if ((INIT_ROUNDS % W) != 0 || INIT_ROUNDS < W) begin : g_bad_init
        $error("trivium_keystream_par: INIT_ROUNDS must be a positive multiple of W");
    end

    fsm_t             fsm;
    fsm_t             fsm_next;
    state_t           state;
    logic [CNT_W-1:0] step_cnt;
    logic             advance;
    logic             out_step;
    logic             cnt_inc;

    state_t           chain [0:W];
    logic   [W-1:0]   z_word;

    assign chain[0] = state;

    for (genvar i = 0; i < W; i++) begin : g_round
        trivium_round u_round (
            .s_in  (chain[i]),
            .s_out (chain[i+1]),
            .z     (z_word[i])
        );
    end

    always_comb begin
        fsm_next = fsm;
        advance  = 1'b0;
        out_step = 1'b0;
        cnt_inc  = 1'b0;
        if (load_i) begin
            fsm_next = INIT;
        end else begin
            unique case (fsm)
                IDLE: ;
                INIT: begin
                    if (en) begin
                        advance = 1'b1;
                        cnt_inc = 1'b1;
                        if (step_cnt == CNT_W'(INIT_STEPS - 1)) begin
                            fsm_next = RUN;
                        end
                    end
                end
                RUN: begin
                    // Only produce into an empty or draining output register: stalls lose nothing.
                    if (en && (!ks_valid_o || ks_ready_i)) begin
                        advance  = 1'b1;
                        out_step = 1'b1;
                    end
                end
                default: fsm_next = IDLE;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= '0;
            step_cnt   <= '0;
            ks_data_o  <= '0;
            ks_valid_o <= 1'b0;
        end else if (load_i) begin
            state      <= load_state(key_i, iv_i);
            step_cnt   <= '0;
            ks_valid_o <= 1'b0;
        end else if (advance) begin
            state <= chain[W];
            if (cnt_inc) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
            if (out_step) begin
                ks_data_o  <= z_word;
                ks_valid_o <= 1'b1;
            end
        end
    end

    assign busy_o = (fsm == INIT);

`ifdef TRIVIUM_WORD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_count_o <= '0;
        end else if (load_i) begin
            ks_count_o <= '0;
        end else if (en && ks_valid_o && ks_ready_i && ks_count_o != 32'hFFFF_FFFF) begin
            ks_count_o <= ks_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trivium_keystream_par.sv
// Self-checking bench: four widths (1/8/32/64) in parallel against a bit-serial A/B/C register model.
// Covers reset, init latency, bit-exactness, backpressure, en gating, reload and mid-run reset.
module tb_trivium_keystream_par;

    localparam int NBITS = 1024;
    localparam int WIDS [4] = '{1, 8, 32, 64};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [79:0] key;
    logic [79:0] iv;
    logic        load;
    logic        ready;

    logic        busy1, busy8, busy32, busy64;
    logic        v1, v8, v32, v64;
    logic [0:0]  d1;
    logic [7:0]  d8;
    logic [31:0] d32;
    logic [63:0] d64;
`ifdef TRIVIUM_WORD_CNT_EN
    logic [31:0] c1, c8, c32, c64;
`endif

    int checks   = 0;
    int failures = 0;

    bit exp_bits [0:NBITS-1];
    bit col      [0:3][0:NBITS-1];
    int col_cnt  [0:3];

    logic        vld [0:3];
    logic [63:0] dat [0:3];

    always #5 clk = ~clk;

    trivium_keystream_par #(.W(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .en(en), .key_i(key), .iv_i(iv), .load_i(load),
        .busy_o(busy1), .ks_data_o(d1), .ks_valid_o(v1), .ks_ready_i(ready)
`ifdef TRIVIUM_WORD_CNT_EN
        , .ks_count_o(c1)
`endif
    );
    trivium_keystream_par #(.W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .en(en), .key_i(key), .iv_i(iv), .load_i(load),
        .busy_o(busy8), .ks_data_o(d8), .ks_valid_o(v8), .ks_ready_i(ready)
`ifdef TRIVIUM_WORD_CNT_EN
        , .ks_count_o(c8)
`endif
    );
    trivium_keystream_par #(.W(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .en(en), .key_i(key), .iv_i(iv), .load_i(load),
        .busy_o(busy32), .ks_data_o(d32), .ks_valid_o(v32), .ks_ready_i(ready)
`ifdef TRIVIUM_WORD_CNT_EN
        , .ks_count_o(c32)
`endif
    );
    trivium_keystream_par #(.W(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .en(en), .key_i(key), .iv_i(iv), .load_i(load),
        .busy_o(busy64), .ks_data_o(d64), .ks_valid_o(v64), .ks_ready_i(ready)
`ifdef TRIVIUM_WORD_CNT_EN
        , .ks_count_o(c64)
`endif
    );

    assign vld[0] = v1;
    assign vld[1] = v8;
    assign vld[2] = v32;
    assign vld[3] = v64;
    assign dat[0] = 64'(d1);
    assign dat[1] = 64'(d8);
    assign dat[2] = 64'(d32);
    assign dat[3] = d64;

    // Words visible with valid&ready&en at the falling edge are taken on the next rising edge.
    always @(negedge clk) begin
        if (load) begin
            for (int k = 0; k < 4; k++) col_cnt[k] <= 0;
        end else if (rst_n && en && ready) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k] && col_cnt[k] < NBITS) begin
                    for (int j = 0; j < WIDS[k]; j++) col[k][col_cnt[k] + j] <= dat[k][j];
                    col_cnt[k] <= col_cnt[k] + WIDS[k];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: classic three-register Trivium, one bit per round.
    task automatic gen_model(input logic [79:0] k, input logic [79:0] v);
        logic [93:1]  a;
        logic [84:1]  b;
        logic [111:1] c;
        logic         t1, t2, t3;
        a = {13'b0, k};
        b = {4'b0, v};
        c = {3'b111, 108'b0};
        for (int r = 0; r < 1152 + NBITS; r++) begin
            t1 = a[66] ^ a[93];
            t2 = b[69] ^ b[84];
            t3 = c[66] ^ c[111];
            if (r >= 1152) exp_bits[r - 1152] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (a[91] & a[92]) ^ b[78];
            t2 = t2 ^ (b[82] & b[83]) ^ c[87];
            t3 = t3 ^ (c[109] & c[110]) ^ a[69];
            a = {a[92:1], t3};
            b = {b[83:1], t1};
            c = {c[110:1], t2};
        end
    endtask

    task automatic do_load(input logic [79:0] k, input logic [79:0] v);
        key  = k;
        iv   = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_streams(input int budget);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (col_cnt[0] >= NBITS) && (col_cnt[1] >= NBITS) &&
                   (col_cnt[2] >= NBITS) && (col_cnt[3] >= NBITS);
        end
        check("stream_collect_done", 64'(done), 64'd1);
    endtask

    task automatic compare_stream(input int k, input string name);
        logic [63:0] o;
        logic [63:0] e;
        for (int c = 0; c < NBITS / 64; c++) begin
            for (int j = 0; j < 64; j++) begin
                o[j] = col[k][c * 64 + j];
                e[j] = exp_bits[c * 64 + j];
            end
            check($sformatf("%s_w%0d_chunk%0d", name, WIDS[k], c), o, e);
        end
    endtask

    localparam logic [79:0] KEY2 = 80'h0123456789ABCDEF0123;

    initial begin
        int fv8, fv32, fv64, bfall8;
        logic [7:0] held;
        logic [7:0] e8;

        rst_n = 1'b0;
        en    = 1'b1;
        key   = '0;
        iv    = '0;
        load  = 1'b0;
        ready = 1'b1;
        #12;
        check("rst_busy8",  64'(busy8), 64'd0);
        check("rst_valid8", 64'(v8),    64'd0);
        check("rst_data8",  64'(d8),    64'd0);
        check("rst_valid64", 64'(v64),  64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Init latency and bit-exactness, key=0 iv=0.
        gen_model('0, '0);
        do_load('0, '0);
        check("init_busy_after_load", 64'(busy8), 64'd1);
        fv8 = -1; fv32 = -1; fv64 = -1; bfall8 = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (!busy8 && bfall8 < 0) bfall8 = n;
            if (v8  && fv8  < 0) fv8  = n;
            if (v32 && fv32 < 0) fv32 = n;
            if (v64 && fv64 < 0) fv64 = n;
        end
        check("init_busy8_fall_edge",  64'(bfall8), 64'd144);
        check("init_valid8_edge",      64'(fv8),    64'd145);
        check("init_valid32_edge",     64'(fv32),   64'd37);
        check("init_valid64_edge",     64'(fv64),   64'd19);
        wait_streams(2500);
        for (int k = 0; k < 4; k++) compare_stream(k, "zero");

        // Backpressure with the second key.
        gen_model(KEY2, '0);
        do_load(KEY2, '0);
        for (int n = 0; n < 300 && !v8; n++) tick();
        check("bp_valid8_seen", 64'(v8), 64'd1);
        ready = 1'b0;
        held  = d8;
        for (int j = 0; j < 8; j++) e8[j] = exp_bits[j];
        check("bp_first_word", 64'(held), 64'(e8));
        for (int n = 0; n < 20; n++) tick();
        check("bp_data_stable",  64'(d8), 64'(held));
        check("bp_valid_held",   64'(v8), 64'd1);
        ready = 1'b1;
        wait_streams(2500);
        for (int k = 0; k < 4; k++) compare_stream(k, "bp");

        // en held low for 50 edges in the middle of W=8 init.
        do_load('0, '0);
        fv8 = -1;
        for (int n = 1; n <= 400 && fv8 < 0; n++) begin
            if (n == 61)  en = 1'b0;
            if (n == 111) en = 1'b1;
            tick();
            if (n == 110) check("en_busy_held", 64'(busy8), 64'd1);
            if (v8) fv8 = n;
        end
        check("en_valid8_edge", 64'(fv8), 64'd195);

        // Reload in RUN while a word is pending.
        ready = 1'b0;
        tick();
        tick();
        tick();
        check("reload_pre_valid", 64'(v8), 64'd1);
        gen_model(KEY2, '0);
        do_load(KEY2, '0);
        check("reload_valid_cleared", 64'(v8),    64'd0);
        check("reload_busy",          64'(busy8), 64'd1);
`ifdef TRIVIUM_WORD_CNT_EN
        check("reload_count_zero", 64'(c8), 64'd0);
`endif
        ready = 1'b1;
        wait_streams(2500);
        for (int k = 0; k < 4; k++) compare_stream(k, "reload");

        // Asynchronous reset while streaming.
        check("prerst_valid8", 64'(v8), 64'd1);
        rst_n = 1'b0;
        #2;
        check("arst_valid8", 64'(v8),    64'd0);
        check("arst_data8",  64'(d8),    64'd0);
        check("arst_busy8",  64'(busy8), 64'd0);
        check("arst_valid64", 64'(v64),  64'd0);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) tick();
        check("postrst_valid8", 64'(v8),    64'd0);
        check("postrst_busy8",  64'(busy8), 64'd0);
        check("postrst_valid1", 64'(v1),    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trivium_keystream_par.md
Name: trivium_keystream_par

Overview:
- Parametrised successor of the bit-serial Trivium core.
- Produces W keystream bits per clock from one 288-bit state, with a runtime key/IV load port.
- Runs the 1152-round init internally, then streams words over a valid/ready interface.
- Sits between key-management/UART RX (key/IV source) and the keystream FIFO (consumer).

Parameters:
- W, 8, keystream bits per step; legal values 1,2,4,8,16,32,64; other values are an elaboration error.
- INIT_ROUNDS, 1152, number of warm-up rounds; must be divisible by W; INIT_STEPS = INIT_ROUNDS/W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global step enable; when 0 the state, counters and outputs freeze
- key_i  input  80  key; key_i[0] -> s1 ... key_i[79] -> s80
- iv_i  input  80  IV; iv_i[0] -> s94 ... iv_i[79] -> s173
- load_i  input  1  single-cycle pulse; samples key_i/iv_i and starts init
- busy_o  output  1  high while in INIT
- ks_data_o  output  W  keystream word; bit 0 is the earliest-generated bit
- ks_valid_o  output  1  ks_data_o valid
- ks_ready_i  input  1  consumer accepts the word when valid & ready

Behaviour:
- Reset is asynchronous active-low on rst_n, single clock clk.
- Reset values: state=0, FSM=IDLE, busy_o=0, ks_valid_o=0, ks_data_o=0, step counter=0.
- FSM has three states: IDLE, INIT, RUN.
- IDLE: outputs idle. load_i does the following:
  - s1..s80=key, s81..s93=0;
  - s94..s173=iv, s174..s177=0;
  - s178..s285=0, s286..s288=1;
  - counter=0, go to INIT.
- load_i is honoured regardless of en and in every state. Mid-INIT or mid-RUN it aborts and reloads, and clears ks_valid_o the same edge. Any unaccepted word is discarded.
- INIT: each edge with en=1 performs W rounds, discarding output, and increments the counter. When counter reaches INIT_STEPS-1 on a stepping edge, go to RUN. busy_o=1 throughout INIT.
- RUN: step when en=1 and (ks_valid_o=0 or ks_ready_i=1). A step does three things: registers W new bits into ks_data_o, sets ks_valid_o=1, advances the state by W rounds.
- RUN with no step: if ks_ready_i=1 and en=1, clear ks_valid_o. Otherwise hold ks_data_o and ks_valid_o stable.
- Stall is lossless: the state never advances unless a word is produced into an empty or being-accepted output register.
- Latency: load_i at edge k gives INIT steps at edges k+1..k+INIT_STEPS. The first RUN step is edge k+INIT_STEPS+1, so ks_valid_o rises after that edge (en=1 throughout).
- Throughput is one W-bit word per cycle under continuous ready.
- Round function (1-indexed state, bit i=0..W-1 computed combinationally in series):
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z_i=t1^t2^t3;
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69;
  - shift each register by one: s1<=t3, s94<=t1, s178<=t2.
- W<=64 guarantees no tap is overwritten within a step.
- Output is bit-exact with W=1 run W times.
- Load/handshake collision: load_i together with valid&ready counts as an accepted word, then the reload happens.

Optional Feature:
- Macro: TRIVIUM_WORD_CNT_EN.
- When defined: adds output ks_count_o [31:0], the count of accepted words (valid&ready) since the last load_i or reset.
  - Saturates at 0xFFFFFFFF.
  - Cleared by load_i on the same edge.
- When undefined: port absent, no counter logic.

Decomposition:
- Package trivium_pkg holds:
  - state length 288;
  - tap index constants (66,93,91,92,171,162,177,175,176,264,243,288,286,287,69);
  - register boundaries 93/177/288;
  - INIT_ROUNDS default;
  - FSM state enum {IDLE, INIT, RUN}.
- One sub-module, trivium_round: a purely combinational single round (288-bit state in, 288-bit state and z out), instantiated W times in a generate chain.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> all outputs 0 immediately, FSM IDLE; no ks_valid_o until a new load_i.
- Init timing, W=8, load_i at cycle 10 with en=1 -> busy_o high cycles 11..154 (144 steps); ks_valid_o first high after edge 155; busy_o low from then.
- Bit-exactness: key=0, iv=0 and key=80'h0123456789ABCDEF0123, iv=80'h0 -> first 1024 bits from W=1, 8, 32, 64 instances identical to each other and to the C reference model.
- Backpressure: ks_ready_i low for 20 cycles after the first valid -> ks_data_o stable. On release, the subsequent words continue the same stream with no gap or duplicate versus a never-stalled run.
- en gating: en=0 for 50 cycles mid-INIT -> busy_o stays 1; first valid delayed by exactly 50 cycles.
- Reload: load_i with a new key in RUN while ks_valid_o=1, ready=0 -> ks_valid_o=0 the next cycle; the stream equals a fresh-load stream. With TRIVIUM_WORD_CNT_EN, ks_count_o returns to 0.
